// File: rtl/frame_read_arbiter.sv
// frame_read_arbiter
//   Shares the single frame-buffer read port between VGA scan-out (priority)
//   and AXI pixel readback, and sequences the capture freeze so that
//   freeze_frame only changes on a frame boundary (vsync falling edge).
//
// Ports:
//   i_clk25, i_reset                 clock, synchronous active-high reset
//   i_vga_en, i_vga_addr             VGA read request, one per cycle
//   o_vga_pixel, o_vga_valid         VGA read data, RD_LAT+1 cycles later
//   i_vsync                          VGA vsync, active low
//   i_axi_req, i_axi_addr            AXI read request (level) and address
//   o_axi_ack, o_axi_data            one-cycle ack with read data
//   i_freeze_req                     software freeze request (level)
//   o_freeze_frame, o_frozen         capture halt / freeze status
//   o_mem_addr, i_mem_data           BRAM read port
//
// Freeze FSM:
//   state        | meaning
//   LIVE         | capture running, no freeze requested
//   FREEZE_PEND  | freeze requested, waiting for frame boundary
//   FROZEN       | capture halted, status reports frozen
//   RELEASE_PEND | release requested, capture still halted until boundary
module frame_read_arbiter #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 12,
  parameter int RD_LAT       = 1,
  parameter int FRAME_PIXELS = 307200
) (
  input  logic              i_clk25,
  input  logic              i_reset,
  input  logic              i_vga_en,
  input  logic [ADDR_W-1:0] i_vga_addr,
  output logic [DATA_W-1:0] o_vga_pixel,
  output logic              o_vga_valid,
  input  logic              i_vsync,
  input  logic              i_axi_req,
  input  logic [ADDR_W-1:0] i_axi_addr,
  output logic              o_axi_ack,
  output logic [DATA_W-1:0] o_axi_data,
  input  logic              i_freeze_req,
  output logic              o_freeze_frame,
  output logic              o_frozen,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_data
);

  typedef enum logic [1:0] {TAG_NONE, TAG_V, TAG_A} tag_t;
  typedef enum logic [1:0] {LIVE, FREEZE_PEND, FROZEN, RELEASE_PEND} state_t;

  localparam logic [ADDR_W:0] LP_FRAME = (ADDR_W+1)'(FRAME_PIXELS);

  tag_t              r_tag [RD_LAT+1];
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_vga_pixel;
  logic              r_vga_valid;
  logic [DATA_W-1:0] r_axi_data;
  logic              r_axi_ack;
  logic              r_vsync_d;
  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_freeze_frame;
  logic              r_frozen;

  logic w_axi_in_flight;
  logic w_axi_ok;
  logic w_axi_oor;
  logic w_grant_a;
  logic w_oor_ack;
  logic w_fb;

  always_comb begin
    w_axi_in_flight = 1'b0;
    for (int i = 0; i <= RD_LAT; i++) begin
      if (r_tag[i] == TAG_A) w_axi_in_flight = 1'b1;
    end
  end

  // An ack being issued this cycle blocks a new grant, so a master that is
  // still holding axi_req during its ack cycle is not served twice.
  assign w_axi_ok  = i_axi_req && !w_axi_in_flight && !r_axi_ack;
  assign w_axi_oor = {1'b0, i_axi_addr} >= LP_FRAME;
  assign w_grant_a = w_axi_ok && !w_axi_oor && !i_vga_en;
  // Out-of-range reads never touch memory, so they bypass VGA priority.
  assign w_oor_ack = w_axi_ok && w_axi_oor;
  assign w_fb      = r_vsync_d && !i_vsync;

  always_ff @(posedge i_clk25) begin
    if (i_reset) begin
      for (int i = 0; i <= RD_LAT; i++) r_tag[i] <= TAG_NONE;
      r_mem_addr  <= '0;
      r_vga_pixel <= '0;
      r_vga_valid <= 1'b0;
      r_axi_data  <= '0;
      r_axi_ack   <= 1'b0;
      r_vsync_d   <= 1'b0;
    end else begin
      r_vsync_d <= i_vsync;

      if (i_vga_en) begin
        r_mem_addr <= i_vga_addr;
        r_tag[0]   <= TAG_V;
      end else if (w_grant_a) begin
        r_mem_addr <= i_axi_addr;
        r_tag[0]   <= TAG_A;
      end else begin
        r_tag[0]   <= TAG_NONE;
      end
      for (int i = 1; i <= RD_LAT; i++) r_tag[i] <= r_tag[i-1];

      r_vga_valid <= 1'b0;
      r_axi_ack   <= 1'b0;
      if (r_tag[RD_LAT] == TAG_V) begin
        r_vga_valid <= 1'b1;
        r_vga_pixel <= i_mem_data;
      end
      // A retiring AXI tag and an out-of-range ack are mutually exclusive
      // because the in-flight check blocks the latter.
      if (r_tag[RD_LAT] == TAG_A) begin
        r_axi_ack  <= 1'b1;
        r_axi_data <= i_mem_data;
      end else if (w_oor_ack) begin
        r_axi_ack  <= 1'b1;
        r_axi_data <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      LIVE:         if (i_freeze_req) w_state_nxt = FREEZE_PEND;
      FREEZE_PEND:  if (!i_freeze_req) w_state_nxt = LIVE;
                    else if (w_fb)     w_state_nxt = FROZEN;
      FROZEN:       if (!i_freeze_req) w_state_nxt = RELEASE_PEND;
      RELEASE_PEND: if (i_freeze_req)  w_state_nxt = FROZEN;
                    else if (w_fb)     w_state_nxt = LIVE;
      default:      w_state_nxt = LIVE;
    endcase
  end

  always_ff @(posedge i_clk25) begin
    if (i_reset) begin
      r_state        <= LIVE;
      r_freeze_frame <= 1'b0;
      r_frozen       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_freeze_frame <= (w_state_nxt == FROZEN) || (w_state_nxt == RELEASE_PEND);
      r_frozen       <= (w_state_nxt == FROZEN);
    end
  end

  assign o_vga_pixel    = r_vga_pixel;
  assign o_vga_valid    = r_vga_valid;
  assign o_axi_ack      = r_axi_ack;
  assign o_axi_data     = r_axi_data;
  assign o_freeze_frame = r_freeze_frame;
  assign o_frozen       = r_frozen;
  assign o_mem_addr     = r_mem_addr;

endmodule

// File: tb/tb_frame_read_arbiter.sv
module tb_frame_read_arbiter;

  logic        clk25 = 1'b0;
  logic        reset = 1'b1;
  logic        vga_en = 1'b0;
  logic [18:0] vga_addr = '0;
  logic [11:0] vga_pixel;
  logic        vga_valid;
  logic        vsync = 1'b1;
  logic        axi_req = 1'b0;
  logic [18:0] axi_addr = '0;
  logic        axi_ack;
  logic [11:0] axi_data;
  logic        freeze_req = 1'b0;
  logic        freeze_frame;
  logic        frozen;
  logic [18:0] mem_addr;
  logic [11:0] mem_data;
  logic [11:0] r_mem_q = '0;

  int n_vec  = 0;
  int n_fail = 0;

  always #20 clk25 = ~clk25;

  // BRAM model, one-cycle latency, returns address[11:0]
  always @(posedge clk25) r_mem_q <= mem_addr[11:0];
  assign mem_data = r_mem_q;

  frame_read_arbiter #(.ADDR_W(19), .DATA_W(12), .RD_LAT(1), .FRAME_PIXELS(307200)) dut (
    .i_clk25(clk25), .i_reset(reset),
    .i_vga_en(vga_en), .i_vga_addr(vga_addr),
    .o_vga_pixel(vga_pixel), .o_vga_valid(vga_valid),
    .i_vsync(vsync),
    .i_axi_req(axi_req), .i_axi_addr(axi_addr),
    .o_axi_ack(axi_ack), .o_axi_data(axi_data),
    .i_freeze_req(freeze_req),
    .o_freeze_frame(freeze_frame), .o_frozen(frozen),
    .o_mem_addr(mem_addr), .i_mem_data(mem_data)
  );

  typedef struct {
    logic        rst, ven;
    logic [18:0] vaddr;
    logic        areq;
    logic [18:0] aaddr;
    logic        frq, vs;
    logic        vvalid;
    logic [11:0] vpix;
    logic        aack;
    logic [11:0] adata;
    logic        ff, fz;
    logic [18:0] maddr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic ven, int vaddr, logic frq, logic vs,
                              logic vvalid, int vpix, logic ff, logic fz, int maddr);
    vec_t v;
    v.rst = rst; v.ven = ven; v.vaddr = 19'(vaddr);
    v.areq = 1'b0; v.aaddr = '0; v.frq = frq; v.vs = vs;
    v.vvalid = vvalid; v.vpix = 12'(vpix); v.aack = 1'b0; v.adata = '0;
    v.ff = ff; v.fz = fz; v.maddr = 19'(maddr);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk25);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    int  n_ack, ack_idx, n_stray;
    logic [18:0] ma_before;

    //          rst ven va frq vs  vvl pix ff fz maddr
    tbl.push_back(mk(1, 0, 0, 0, 1,  0, 0, 0, 0, 0));   // reset state
    tbl.push_back(mk(0, 1, 0, 0, 1,  0, 0, 0, 0, 0));   // VGA burst 0..3
    tbl.push_back(mk(0, 1, 1, 0, 1,  0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 2, 0, 1,  1, 0, 0, 0, 2));
    tbl.push_back(mk(0, 1, 3, 0, 1,  1, 1, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1,  1, 2, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1,  1, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 3, 0, 0, 3));   // freeze mid-frame
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 3, 1, 1, 3));   // boundary -> FROZEN
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 3, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 3, 1, 1, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 1, 0, 3));   // RELEASE_PEND
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 3, 0, 0, 3));   // boundary -> LIVE
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 0, 0, 3));
    for (int i = 0; i < 5; i++)                         // 5-cycle pulse
      tbl.push_back(mk(0, 0, 0, 1, 1,  0, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 3, 0, 0, 3));   // boundary, stays LIVE
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 3, 0, 0, 3));   // req + fb in LIVE
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1, 1,  0, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 1, 0,  0, 3, 1, 1, 3));   // next boundary
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 1, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 0,  0, 3, 0, 0, 3));
    tbl.push_back(mk(0, 0, 0, 0, 1,  0, 3, 0, 0, 3));

    #1;
    foreach (tbl[i]) begin
      reset = tbl[i].rst; vga_en = tbl[i].ven; vga_addr = tbl[i].vaddr;
      axi_req = tbl[i].areq; axi_addr = tbl[i].aaddr;
      freeze_req = tbl[i].frq; vsync = tbl[i].vs;
      tick();
      chk($sformatf("vec%0d", i),
          {vga_valid, vga_pixel, axi_ack, axi_data, freeze_frame, frozen, mem_addr},
          {tbl[i].vvalid, tbl[i].vpix, tbl[i].aack, tbl[i].adata, tbl[i].ff, tbl[i].fz, tbl[i].maddr});
    end

    // AXI starved by VGA for 10 cycles, then served in blanking
    vga_en = 1'b1; vga_addr = 19'd5; axi_req = 1'b1; axi_addr = 19'd1000;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("axi_blocked", {axi_ack, mem_addr}, {1'b0, 19'd5});
    end
    vga_en = 1'b0;
    n_ack = 0; ack_idx = -1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) chk("axi_grant_addr", mem_addr, 19'd1000);
      if (axi_ack) begin
        n_ack++;
        if (ack_idx < 0) ack_idx = i;
        chk("axi_data", axi_data, 12'd1000);
        axi_req = 1'b0;
      end
    end
    chk("axi_ack_count", n_ack, 1);
    chk("axi_ack_latency", ack_idx, 2);

    // Out-of-range, VGA idle: immediate ack, zero data, no memory access
    ma_before = mem_addr;
    axi_req = 1'b1; axi_addr = 19'd307200;
    tick();
    chk("oor_ack", {axi_ack, axi_data, mem_addr}, {1'b1, 12'd0, ma_before});
    axi_req = 1'b0;
    tick();
    chk("oor_ack_once", axi_ack, 1'b0);

    // Out-of-range while VGA is reading
    axi_req = 1'b1; axi_addr = 19'h7FFFF; vga_en = 1'b1; vga_addr = 19'd9;
    tick();
    chk("oor_vga_ack", {axi_ack, axi_data, mem_addr}, {1'b1, 12'd0, 19'd9});
    axi_req = 1'b0; vga_en = 1'b0;
    tick(); tick(); tick();

    // Freeze, then reset one cycle after an AXI grant during a VGA burst
    freeze_req = 1'b1; vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    chk("pre_reset_frozen", frozen, 1'b1);
    vsync = 1'b1;
    vga_en = 1'b1; vga_addr = 19'd30;
    tick();
    vga_en = 1'b0; axi_req = 1'b1; axi_addr = 19'd2000;
    tick();
    chk("pre_reset_grant", mem_addr, 19'd2000);
    reset = 1'b1; vga_en = 1'b1; vga_addr = 19'd31;
    tick();
    chk("reset_outputs",
        {vga_valid, vga_pixel, axi_ack, axi_data, freeze_frame, frozen, mem_addr}, 64'd0);
    reset = 1'b0; vga_en = 1'b0; axi_req = 1'b0; freeze_req = 1'b0;
    n_stray = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (vga_valid || axi_ack || freeze_frame || frozen) n_stray++;
    end
    chk("post_reset_stray", n_stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
